tmds_encoder_multi: RTL

Parametrised multi-channel TMDS symbol encoder, successor to the single-channel fixed-function encoder in the HDMI output path. Encodes CHANNELS lanes in parallel per pixel clock: DVI video with a full 5-bit running-disparity counter, control periods, HDMI guard bands and TERC4 data-island symbols. Sits between the video timing/pattern logic and the 10:1 serialisers; outputs are 10-bit symbols, bit 0 sent first on the wire.

---
 rtl/tmds_encoder_multi.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: DVI video with running disparity, control, guard bands, TERC4.
// Optional TERC4/data-island support is enabled by defining TMDS_TERC4_EN.
module tmds_encoder_multi #(
    parameter int CHANNELS = 3
) (
    input  logic                    pixclk,
    input  logic                    reset,
    input  logic [2:0]              mode,
    input  logic [8*CHANNELS-1:0]   vd,
    input  logic [2*CHANNELS-1:0]   cd,
    input  logic [4*CHANNELS-1:0]   aux,
    output logic [10*CHANNELS-1:0]  tmds,
    output logic [5*CHANNELS-1:0]   disp
);
    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_VGUARD = 3'd3;
`ifdef TMDS_TERC4_EN
    localparam logic [2:0] MODE_TERC4  = 3'd2;
    localparam logic [2:0] MODE_DGUARD = 3'd4;
`endif

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4_sym(input logic [3:0] nib);
        case (nib)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction
`else
    logic w_unused_aux;
    assign w_unused_aux = ^aux;
`endif

    logic [2:0] r_mode;

    always_ff @(posedge pixclk) begin
        if (reset) r_mode <= MODE_CTRL;
        else       r_mode <= mode;
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            localparam int ROLE = gi % 3;

            logic [3:0] w_pop;
            logic       w_xnor;
            logic [8:0] w_qm;
            logic [3:0] w_n1;
            logic [8:0] r_qm;
            logic [3:0] r_n1;
            logic [1:0] r_cd;
            logic [4:0] r_cnt;
            logic [9:0] r_sym;
            logic [4:0] w_d;
            logic [4:0] w_cnt_next;
            logic [9:0] w_sym;

            // Stage 1: transition minimisation; XNOR expressed as XOR with the select bit
            always_comb begin
                w_pop = '0;
                for (int i = 0; i < 8; i++) w_pop = w_pop + {3'b0, vd[8*gi+i]};
                w_xnor = (w_pop > 4'd4) || (w_pop == 4'd4 && !vd[8*gi]);
                w_qm[0] = vd[8*gi];
                for (int i = 1; i < 8; i++) w_qm[i] = vd[8*gi+i] ^ w_qm[i-1] ^ w_xnor;
                w_qm[8] = ~w_xnor;
                w_n1 = '0;
                for (int i = 0; i < 8; i++) w_n1 = w_n1 + {3'b0, w_qm[i]};
            end

`ifdef TMDS_TERC4_EN
            logic [3:0] r_aux;
            always_ff @(posedge pixclk) begin
                if (reset) r_aux <= '0;
                else       r_aux <= aux[4*gi +: 4];
            end
`endif

            always_ff @(posedge pixclk) begin
                if (reset) begin
                    r_qm <= '0;
                    r_n1 <= '0;
                    r_cd <= 2'b00;
                end else begin
                    r_qm <= w_qm;
                    r_n1 <= w_n1;
                    r_cd <= cd[2*gi +: 2];
                end
            end

            // n1 - n0 = 2*n1 - 8; 5-bit modular arithmetic stays exact within -10..+10
            assign w_d = {r_n1, 1'b0} - 5'd8;

            always_comb begin
                w_sym      = ctrl_sym(r_cd);
                w_cnt_next = '0;
                case (r_mode)
                    MODE_VIDEO: begin
                        if (r_cnt == 5'd0 || r_n1 == 4'd4) begin
                            w_sym      = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                            w_cnt_next = r_qm[8] ? r_cnt + w_d : r_cnt - w_d;
                        end else if ((!r_cnt[4] && r_n1 > 4'd4) || (r_cnt[4] && r_n1 < 4'd4)) begin
                            w_sym      = {1'b1, r_qm[8], ~r_qm[7:0]};
                            w_cnt_next = r_cnt + {3'b0, r_qm[8], 1'b0} - w_d;
                        end else begin
                            w_sym      = {1'b0, r_qm[8], r_qm[7:0]};
                            w_cnt_next = r_cnt - {3'b0, ~r_qm[8], 1'b0} + w_d;
                        end
                    end
                    MODE_VGUARD: w_sym = (ROLE == 1) ? 10'b0100110011 : 10'b1011001100;
`ifdef TMDS_TERC4_EN
                    MODE_TERC4:  w_sym = terc4_sym(r_aux);
                    MODE_DGUARD: w_sym = (ROLE == 0) ? terc4_sym({2'b11, r_cd}) : 10'b0100110011;
`endif
                    default: ;
                endcase
            end

            always_ff @(posedge pixclk) begin
                if (reset) begin
                    r_sym <= 10'b1101010100;
                    r_cnt <= '0;
                end else begin
                    r_sym <= w_sym;
                    r_cnt <= w_cnt_next;
                end
            end

            assign tmds[10*gi +: 10] = r_sym;
            assign disp[5*gi +: 5]   = r_cnt;
        end
    endgenerate
endmodule
